// File: rtl/sparse_pe_seq.sv
// ============================================================================
// Module      : sparse_pe_seq
// Description : Sparse-weight processing element. Stores tagged nonzero
//               weights and runs a sequenced MAC over a full feature window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sparse_pe_seq #(
    parameter int I_WIDTH   = 8,
    parameter int F_WIDTH   = 8,
    parameter int N         = 3,
    parameter int W_DEPTH   = 4,
    parameter int SEL_WIDTH = $clog2(N),
    parameter int CNT_WIDTH = $clog2(W_DEPTH + 1),
    parameter int ACC_WIDTH = I_WIDTH + F_WIDTH + $clog2(W_DEPTH + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        w_load_i,
    input  logic signed [F_WIDTH-1:0]   w_weight_i,
    input  logic [SEL_WIDTH-1:0]        w_sel_i,
    input  logic                        w_clear_i,
    output logic [CNT_WIDTH-1:0]        w_count_o,
    input  logic                        window_rst_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic signed [I_WIDTH-1:0]   in_feature_i,
    input  logic signed [ACC_WIDTH-1:0] psum_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic signed [ACC_WIDTH-1:0] out_psum_o
);

    localparam int FILL_WIDTH = $clog2(N + 1);
    localparam int PROD_WIDTH = I_WIDTH + F_WIDTH;
    localparam int IDX_WIDTH  = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;

    localparam logic [FILL_WIDTH-1:0] FILL_FULL = FILL_WIDTH'(N);
    localparam logic [CNT_WIDTH-1:0]  DEPTH_CNT = CNT_WIDTH'(W_DEPTH);
    localparam logic [SEL_WIDTH:0]    N_SEL     = (SEL_WIDTH + 1)'(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]                  state;
    logic [SEL_WIDTH-1:0]        wsel [W_DEPTH];
    logic signed [F_WIDTH-1:0]   wval [W_DEPTH];
    logic [CNT_WIDTH-1:0]        count;
    logic [CNT_WIDTH-1:0]        idx;
    logic signed [I_WIDTH-1:0]   win  [N];
    logic [FILL_WIDTH-1:0]       fill;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] out_psum;

    logic                        idle;
    logic                        accept;
    logic                        win_clr;
    logic                        load_ok;
    logic                        trigger;
    logic                        last;
    logic [FILL_WIDTH-1:0]       fill_base;
    logic [FILL_WIDTH-1:0]       fill_next;
    logic [IDX_WIDTH-1:0]        mac_ix;
    logic [IDX_WIDTH-1:0]        load_ix;
    logic signed [PROD_WIDTH-1:0] product;
    logic signed [ACC_WIDTH-1:0] acc_next;

    assign idle    = (state == S_IDLE);
    assign accept  = in_valid_i & idle;
    assign win_clr = window_rst_i & idle;
    assign load_ok = idle & w_load_i & ~w_clear_i & (count != DEPTH_CNT)
                   & ({1'b0, w_sel_i} < N_SEL);

    // Window reset takes effect before a coincident feature is counted.
    assign fill_base = win_clr ? '0 : fill;
    assign fill_next = !accept ? fill_base :
                       (fill_base == FILL_FULL) ? FILL_FULL : fill_base + 1'b1;
    assign trigger   = accept & (fill_next == FILL_FULL);

    assign mac_ix   = idx[IDX_WIDTH-1:0];
    assign load_ix  = count[IDX_WIDTH-1:0];
    assign product  = win[wsel[mac_ix]] * wval[mac_ix];
    assign acc_next = acc + {{(ACC_WIDTH - PROD_WIDTH){product[PROD_WIDTH-1]}}, product};
    assign last     = (idx == count - CNT_WIDTH'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= S_IDLE;
            count    <= '0;
            idx      <= '0;
            fill     <= '0;
            acc      <= '0;
            out_psum <= '0;
            for (int i = 0; i < W_DEPTH; i++) begin
                wsel[i] <= '0;
                wval[i] <= '0;
            end
            for (int k = 0; k < N; k++) begin
                win[k] <= '0;
            end
        end else begin
            if (idle && w_clear_i) begin
                count <= '0;
            end else if (load_ok) begin
                wsel[load_ix] <= w_sel_i;
                wval[load_ix] <= w_weight_i;
                count         <= count + 1'b1;
            end

            if (accept) begin
                win[0] <= in_feature_i;
                for (int k = 1; k < N; k++) begin
                    win[k] <= win_clr ? '0 : win[k-1];
                end
            end else if (win_clr) begin
                for (int k = 0; k < N; k++) begin
                    win[k] <= '0;
                end
            end

            if (accept || win_clr) begin
                fill <= fill_next;
            end

            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        acc <= psum_i;
                        idx <= '0;
                        if (count == '0) begin
                            out_psum <= psum_i;
                            state    <= S_OUT;
                        end else begin
                            state <= S_MAC;
                        end
                    end
                end
                S_MAC: begin
                    acc <= acc_next;
                    idx <= idx + 1'b1;
                    if (last) begin
                        out_psum <= acc_next;
                        state    <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready_i) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready_o  = idle;
    assign out_valid_o = (state == S_OUT);
    assign out_psum_o  = out_psum;
    assign w_count_o   = count;

endmodule

`default_nettype wire

// File: tb/tb_sparse_pe_seq.sv
// ============================================================================
// Module      : tb_sparse_pe_seq
// Description : Directed vector bench for sparse_pe_seq (default and
//               single-weight configurations).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sparse_pe_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Default configuration: ACC_WIDTH = 19, CNT_WIDTH = 3
    logic              w_load = 1'b0, w_clear = 1'b0, window_rst = 1'b0;
    logic signed [7:0] w_weight = '0;
    logic [1:0]        w_sel = '0;
    logic [2:0]        w_count;
    logic              in_valid = 1'b0, in_ready;
    logic signed [7:0] in_feature = '0;
    logic signed [18:0] psum = '0;
    logic              out_valid, out_ready = 1'b1;
    logic signed [18:0] out_psum;

    // Single-weight configuration: ACC_WIDTH = 17, CNT_WIDTH = 1
    logic              b_load = 1'b0, b_clear = 1'b0, b_wrst = 1'b0;
    logic signed [7:0] b_weight = '0;
    logic [1:0]        b_sel = '0;
    logic [0:0]        b_count;
    logic              b_valid = 1'b0, b_ready;
    logic signed [7:0] b_feature = '0;
    logic signed [16:0] b_psum = '0;
    logic              b_ovalid, b_oready = 1'b1;
    logic signed [16:0] b_opsum;

    sparse_pe_seq dut (
        .clk_i(clk), .rst_ni(rst_n),
        .w_load_i(w_load), .w_weight_i(w_weight), .w_sel_i(w_sel),
        .w_clear_i(w_clear), .w_count_o(w_count), .window_rst_i(window_rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_feature_i(in_feature),
        .psum_i(psum), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_psum_o(out_psum)
    );

    sparse_pe_seq #(.W_DEPTH(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .w_load_i(b_load), .w_weight_i(b_weight), .w_sel_i(b_sel),
        .w_clear_i(b_clear), .w_count_o(b_count), .window_rst_i(b_wrst),
        .in_valid_i(b_valid), .in_ready_o(b_ready), .in_feature_i(b_feature),
        .psum_i(b_psum), .out_valid_o(b_ovalid), .out_ready_i(b_oready),
        .out_psum_o(b_opsum)
    );

    typedef struct {
        int ld, wt, sel, clr, wrst, vld, feat, ps, ordy;
        int e_cnt, e_rdy, e_ov, chk, e_ps;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void add(int ld, int wt, int sel, int clr, int wrst,
                                int vld, int feat, int ps, int ordy,
                                int e_cnt, int e_rdy, int e_ov, int chk, int e_ps);
        vec_t v;
        v = '{ld, wt, sel, clr, wrst, vld, feat, ps, ordy, e_cnt, e_rdy, e_ov, chk, e_ps};
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        w_load = 0; w_clear = 0; window_rst = 0; in_valid = 0;
        w_weight = '0; w_sel = '0; in_feature = '0; psum = '0;
    endtask

    initial begin
        // Columns: ld wt sel clr wrst | vld feat ps ordy || cnt rdy ov chk psum
        add(1,  2, 0, 0, 0,  0, 0,  0, 1,  1, 1, 0, 0, 0);
        add(1, -3, 2, 0, 0,  0, 0,  0, 1,  2, 1, 0, 0, 0);
        add(0,  0, 0, 0, 0,  1, 1,  0, 1,  2, 1, 0, 0, 0);
        add(0,  0, 0, 0, 0,  1, 2,  0, 1,  2, 1, 0, 0, 0);
        add(0,  0, 0, 0, 0,  1, 3, 10, 1,  2, 0, 0, 0, 0);   // trigger, K=2
        add(1,  5, 1, 0, 0,  0, 0,  0, 1,  2, 0, 0, 0, 0);   // load during MAC dropped
        add(0,  0, 0, 0, 0,  0, 0,  0, 1,  2, 0, 1, 1, 13);
        add(0,  0, 0, 0, 0,  0, 0,  0, 1,  2, 1, 0, 1, 13);
        add(0,  0, 0, 0, 0,  1, 4,  0, 1,  2, 0, 0, 0, 0);   // window {4,3,2}
        add(0,  0, 0, 0, 0,  0, 0,  0, 1,  2, 0, 0, 0, 0);
        add(0,  0, 0, 0, 0,  0, 0,  0, 1,  2, 0, 1, 1, 2);
        add(0,  0, 0, 0, 0,  0, 0,  0, 1,  2, 1, 0, 0, 0);
        add(0,  0, 0, 1, 0,  0, 0,  0, 1,  0, 1, 0, 0, 0);   // clear
        add(1,  7, 1, 0, 0,  0, 0,  0, 1,  1, 1, 0, 0, 0);
        add(1,  7, 1, 1, 0,  0, 0,  0, 1,  0, 1, 0, 0, 0);   // clear beats load
        add(0,  0, 0, 0, 0,  1, 5, -7, 1,  0, 0, 1, 1, -7);  // count 0 -> OUT
        add(0,  0, 0, 0, 0,  0, 0,  0, 1,  0, 1, 0, 0, 0);
        add(1,  9, 3, 0, 0,  0, 0,  0, 1,  0, 1, 0, 0, 0);   // sel >= N dropped
        add(1,  1, 0, 0, 0,  0, 0,  0, 1,  1, 1, 0, 0, 0);
        add(1,  1, 1, 0, 0,  0, 0,  0, 1,  2, 1, 0, 0, 0);
        add(1,  1, 2, 0, 0,  0, 0,  0, 1,  3, 1, 0, 0, 0);
        add(1,  1, 0, 0, 0,  0, 0,  0, 1,  4, 1, 0, 0, 0);
        add(1, 50, 1, 0, 0,  0, 0,  0, 1,  4, 1, 0, 0, 0);   // store full
        add(0,  0, 0, 0, 0,  1, 6,100, 0,  4, 0, 0, 0, 0);   // window {6,5,4}, K=4
        add(0,  0, 0, 0, 0,  0, 0,  0, 0,  4, 0, 0, 0, 0);
        add(0,  0, 0, 0, 0,  0, 0,  0, 0,  4, 0, 0, 0, 0);
        add(0,  0, 0, 0, 0,  0, 0,  0, 0,  4, 0, 0, 0, 0);
        add(0,  0, 0, 0, 0,  1, 9,  0, 0,  4, 0, 1, 1, 121); // stalled in OUT
        add(0,  0, 0, 0, 0,  1, 9,  0, 0,  4, 0, 1, 1, 121);
        add(0,  0, 0, 0, 0,  1, 9,  0, 0,  4, 0, 1, 1, 121);
        add(0,  0, 0, 0, 0,  1, 9,  0, 0,  4, 0, 1, 1, 121);
        add(0,  0, 0, 0, 0,  1, 9,  0, 1,  4, 1, 0, 1, 121);
        add(0,  0, 0, 0, 0,  1, 9,  0, 1,  4, 0, 0, 0, 0);   // window {9,6,5}
        add(0,  0, 0, 0, 0,  0, 0,  0, 1,  4, 0, 0, 0, 0);
        add(0,  0, 0, 0, 0,  0, 0,  0, 1,  4, 0, 0, 0, 0);
        add(0,  0, 0, 0, 0,  0, 0,  0, 1,  4, 0, 0, 0, 0);
        add(0,  0, 0, 0, 0,  0, 0,  0, 1,  4, 0, 1, 1, 29);
        add(0,  0, 0, 0, 0,  0, 0,  0, 1,  4, 1, 0, 0, 0);
        add(0,  0, 0, 0, 1,  1, 1,  0, 1,  4, 1, 0, 0, 0);   // window reset + feature
        add(0,  0, 0, 0, 0,  1, 2,  0, 1,  4, 1, 0, 0, 0);
        add(0,  0, 0, 0, 0,  1, 3,  0, 1,  4, 0, 0, 0, 0);   // window {3,2,1}
        add(0,  0, 0, 0, 0,  0, 0,  0, 1,  4, 0, 0, 0, 0);
        add(0,  0, 0, 0, 0,  0, 0,  0, 1,  4, 0, 0, 0, 0);
        add(0,  0, 0, 0, 0,  0, 0,  0, 1,  4, 0, 0, 0, 0);
        add(0,  0, 0, 0, 0,  0, 0,  0, 1,  4, 0, 1, 1, 9);
        add(0,  0, 0, 0, 0,  0, 0,  0, 1,  4, 1, 0, 0, 0);

        // Reset state
        tick();
        check("rst.count", int'(w_count), 0);
        check("rst.ovalid", int'(out_valid), 0);
        check("rst.psum", int'(out_psum), 0);
        rst_n = 1'b1;
        tick();
        check("rst.ready", int'(in_ready), 1);

        foreach (tbl[i]) begin
            w_load = 1'(tbl[i].ld); w_weight = 8'(tbl[i].wt); w_sel = 2'(tbl[i].sel);
            w_clear = 1'(tbl[i].clr); window_rst = 1'(tbl[i].wrst);
            in_valid = 1'(tbl[i].vld); in_feature = 8'(tbl[i].feat);
            psum = 19'(tbl[i].ps); out_ready = 1'(tbl[i].ordy);
            tick();
            check($sformatf("v%0d.count", i), int'(w_count), tbl[i].e_cnt);
            check($sformatf("v%0d.ready", i), int'(in_ready), tbl[i].e_rdy);
            check($sformatf("v%0d.ovalid", i), int'(out_valid), tbl[i].e_ov);
            if (tbl[i].chk != 0)
                check($sformatf("v%0d.psum", i), int'(out_psum), tbl[i].e_ps);
        end
        idle_inputs();
        out_ready = 1'b1;

        // Asynchronous reset in the middle of a MAC run
        in_valid = 1; in_feature = 8'sd1;
        tick();
        idle_inputs();
        tick();
        check("amid.ready", int'(in_ready), 0);
        #2 rst_n = 1'b0;
        #1;
        check("areset.ovalid", int'(out_valid), 0);
        check("areset.count", int'(w_count), 0);
        check("areset.ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        in_valid = 1; in_feature = 8'sd4;
        tick();
        check("post.f1.ovalid", int'(out_valid), 0);
        check("post.f1.ready", int'(in_ready), 1);
        in_feature = 8'sd5;
        tick();
        check("post.f2.ovalid", int'(out_valid), 0);
        check("post.f2.ready", int'(in_ready), 1);
        in_feature = 8'sd6; psum = -19'sd5;
        tick();
        idle_inputs();
        check("post.f3.ovalid", int'(out_valid), 1);
        check("post.f3.psum", int'(out_psum), -5);
        tick();
        check("post.idle", int'(in_ready), 1);

        // Accumulator wrap in the single-weight configuration
        b_load = 1; b_weight = -8'sd128; b_sel = 2'd0;
        tick();
        check("wrap.count1", int'(b_count), 1);
        b_weight = 8'sd5; b_sel = 2'd1;
        tick();
        check("wrap.full", int'(b_count), 1);
        b_load = 0;
        b_valid = 1; b_feature = -8'sd128;
        tick();
        tick();
        b_psum = 17'sd65535;
        tick();
        b_valid = 0; b_psum = '0;
        check("wrap.mac.ovalid", int'(b_ovalid), 0);
        tick();
        check("wrap.ovalid", int'(b_ovalid), 1);
        check("wrap.psum", int'(b_opsum), -49153);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
